// File: rtl/citadel_sequence_lock.sv
// citadel_sequence_lock: sequence-entry lock with constant-time key compare,
// failure counting, timed lockout and an inactivity timeout during entry.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   ena               - power-state enable, gates seg_out/status_out only
//   key_in, key_valid - key symbol and its strobe
//   relock            - re-arm request (honoured only while unlocked)
//   in_ready          - symbols are accepted this cycle
//   unlocked, lockout - authorised / lockout active
//   attempts_left     - remaining tries before lockout
//   seg_out           - active-low 7-segment {dp,g,f,e,d,c,b,a}
//   status_out        - status byte
// All outputs are registered from the next-state values, so they track the
// state register cycle for cycle.
module citadel_sequence_lock #(
    parameter int                            DATA_W         = 8,
    parameter int                            KEY_BYTES      = 4,
    parameter logic [DATA_W*KEY_BYTES-1:0]   KEY            = 32'hB65AC30F,
    parameter int                            MAX_ATTEMPTS   = 3,
    parameter int                            LOCKOUT_CYCLES = 1024,
    parameter int                            ENTRY_TIMEOUT  = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic [DATA_W-1:0]                 key_in,
    input  logic                              key_valid,
    input  logic                              relock,
    output logic                              in_ready,
    output logic                              unlocked,
    output logic                              lockout,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left,
    output logic [7:0]                        seg_out,
    output logic [7:0]                        status_out
);
    localparam int AW = $clog2(MAX_ATTEMPTS+1);
    localparam int IW = $clog2(KEY_BYTES);
    localparam int LW = $clog2(LOCKOUT_CYCLES+1);
    localparam int TW = $clog2(ENTRY_TIMEOUT+1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(KEY_BYTES-1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES-1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ENTRY_TIMEOUT-1);
    localparam logic [AW-1:0] MAX_FAIL  = AW'(MAX_ATTEMPTS);

    typedef enum logic [1:0] {S_LOCKED, S_ENTRY, S_VERIFIED, S_LOCKOUT} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic              mism, mism_n;
    logic [AW-1:0]     fail_cnt, fail_n, fail_inc;
    logic [TW-1:0]     tmo_cnt, tmo_n;
    logic [LW-1:0]     lock_cnt, lock_n;
    logic              accept, sym_bad, verdict, attempt_bad;
    logic              in_ready_n, unlocked_n, lockout_n;
    logic [AW-1:0]     attempts_n;
    logic [7:0]        seg_n, status_n;

    // Key symbols re-ordered so that entry index i selects symbol i (MSB first).
    logic [KEY_BYTES-1:0][DATA_W-1:0] key_syms;
    for (genvar g = 0; g < KEY_BYTES; g++) begin : g_key
        assign key_syms[g] = KEY[DATA_W*(KEY_BYTES-1-g) +: DATA_W];
    end

    // Mismatch is always evaluated and accumulated; no early exit, so every
    // attempt takes the same number of symbols regardless of where it differs.
    assign sym_bad = |(key_in ^ key_syms[idx]);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        mism_n      = mism;
        fail_n      = fail_cnt;
        fail_inc    = fail_cnt + 1'b1;
        tmo_n       = tmo_cnt;
        lock_n      = lock_cnt;
        verdict     = 1'b0;
        attempt_bad = 1'b0;
        accept      = key_valid && (state == S_LOCKED || state == S_ENTRY);

        case (state)
            S_LOCKED: begin
                if (accept) begin
                    state_n = S_ENTRY;
                    idx_n   = IW'(1);
                    mism_n  = sym_bad;
                    tmo_n   = '0;
                end
            end
            S_ENTRY: begin
                if (accept) begin
                    tmo_n = '0;
                    if (idx == LAST_IDX) begin
                        verdict     = 1'b1;
                        attempt_bad = mism | sym_bad;
                    end else begin
                        idx_n  = idx + 1'b1;
                        mism_n = mism | sym_bad;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    // Inactivity abort counts as a failed attempt.
                    verdict     = 1'b1;
                    attempt_bad = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            S_VERIFIED: begin
                // relock wins over key_valid; symbols are never accepted here.
                if (relock) state_n = S_LOCKED;
            end
            S_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_n = S_LOCKED;
                    fail_n  = '0;
                end else begin
                    lock_n = lock_cnt - 1'b1;
                end
            end
            default: state_n = S_LOCKED;
        endcase

        if (verdict) begin
            idx_n  = '0;
            mism_n = 1'b0;
            tmo_n  = '0;
            if (!attempt_bad) begin
                state_n = S_VERIFIED;
                fail_n  = '0;
            end else begin
                fail_n = fail_inc;
                if (fail_inc == MAX_FAIL) begin
                    state_n = S_LOCKOUT;
                    lock_n  = LOCK_LOAD;
                end else begin
                    state_n = S_LOCKED;
                end
            end
        end

        in_ready_n = (state_n == S_LOCKED) || (state_n == S_ENTRY);
        unlocked_n = (state_n == S_VERIFIED);
        lockout_n  = (state_n == S_LOCKOUT);
        attempts_n = lockout_n ? '0 : MAX_FAIL - fail_n;

        case (state_n)
            S_VERIFIED: seg_n = 8'hC1;
            S_LOCKOUT:  seg_n = 8'hBF;
            default:    seg_n = 8'hC7;
        endcase
        if (!ena) seg_n = 8'hFF;

        if (!ena)            status_n = 8'h00;
        else if (unlocked_n) status_n = 8'hFF;
        else                 status_n = {lockout_n, state_n == S_ENTRY, 6'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOCKED;
            idx           <= '0;
            mism          <= 1'b0;
            fail_cnt      <= '0;
            tmo_cnt       <= '0;
            lock_cnt      <= '0;
            in_ready      <= 1'b1;
            unlocked      <= 1'b0;
            lockout       <= 1'b0;
            attempts_left <= MAX_FAIL;
            seg_out       <= ena ? 8'hC7 : 8'hFF;
            status_out    <= 8'h00;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            mism          <= mism_n;
            fail_cnt      <= fail_n;
            tmo_cnt       <= tmo_n;
            lock_cnt      <= lock_n;
            in_ready      <= in_ready_n;
            unlocked      <= unlocked_n;
            lockout       <= lockout_n;
            attempts_left <= attempts_n;
            seg_out       <= seg_n;
            status_out    <= status_n;
        end
    end
endmodule
